// File: rtl/fp_div_iter_if.sv
// Handshake and operand bus for fp_div_iter.
// The master drives the start request and operands; the slave (the divider)
// returns busy, the one-cycle valid pulse, the quotient and the exception flag.
interface fp_div_iter_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         enable;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         busy;
  logic         valid;
  logic [W-1:0] z;
  logic [1:0]   overflow;

  modport master (
    output enable, x, y,
    input  busy, valid, z, overflow
  );

  modport slave (
    input  enable, x, y,
    output busy, valid, z, overflow
  );
endinterface

// File: rtl/fp_div_iter.sv
// Iterative floating-point divider z = x / y with configurable exponent and
// mantissa widths. The mantissa quotient comes from a one-bit-per-cycle
// restoring divider. Denormal inputs are read as signed zero and denormal
// results flush to zero.
//
// Build option: FP_DIV_ROUND_EN selects round-to-nearest-even; without it the
// quotient is truncated (round toward zero).
//
// state  | meaning
// -------+-----------------------------------------------------------------
// S_IDLE | waiting for enable; operands captured on the accept edge
// S_DIV  | restoring division, one quotient bit per cycle, counter to 0
// S_NORM | quotient below 1.0 is shifted left and the exponent decremented
// S_PACK | round, range check, register z/overflow and pulse valid
// S_SPEC | zero/inf/NaN operand: emit the precomputed special result
module fp_div_iter #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic           clk,
  input logic           rst,
  fp_div_iter_if.slave  div_if
);

  localparam int W     = 1 + EXP_W + MAN_W;
  // Quotient bits: hidden, MAN_W mantissa, guard, plus one spare so that a
  // quotient below 1.0 still has a guard bit after the normalising shift.
  localparam int QW    = MAN_W + 3;
  localparam int CNT_W = $clog2(QW);
  localparam int BIAS  = (1 << (EXP_W - 1)) - 1;
  localparam int EW    = EXP_W + 2;

  localparam logic [EXP_W-1:0]      EXP_ONES = '1;
  localparam logic signed [EW-1:0]  EXP_TOP  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0]  EXP_ZERO = EW'(0);
  localparam logic [CNT_W-1:0]      CNT_LOAD = CNT_W'(QW - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIV,
    S_NORM,
    S_PACK,
    S_SPEC
  } state_t;

  state_t                  state_q, state_d;
  logic                    sign_q, sign_d;
  logic signed [EW-1:0]    exp_q, exp_d;
  logic [MAN_W+1:0]        rem_q, rem_d;
  logic [MAN_W:0]          dvs_q, dvs_d;
  logic [QW-1:0]           quo_q, quo_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [W-1:0]            spz_q, spz_d;
  logic [1:0]              spf_q, spf_d;
  logic [W-1:0]            z_q, z_d;
  logic [1:0]              ovf_q, ovf_d;
  logic                    valid_q, valid_d;

  // Operand fields and classification, only meaningful on the accept edge.
  logic                    xs, ys;
  logic [EXP_W-1:0]        xe, ye;
  logic [MAN_W-1:0]        xm, ym;
  logic                    x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;
  logic                    x_spec, y_spec, sgn;
  logic [W-1:0]            z_qnan, z_inf, z_zero;

  assign {xs, xe, xm} = div_if.x;
  assign {ys, ye, ym} = div_if.y;

  assign x_zero = (xe == '0);
  assign y_zero = (ye == '0);
  assign x_inf  = (xe == EXP_ONES) && (xm == '0);
  assign y_inf  = (ye == EXP_ONES) && (ym == '0);
  assign x_nan  = (xe == EXP_ONES) && (xm != '0);
  assign y_nan  = (ye == EXP_ONES) && (ym != '0);
  assign x_spec = x_zero || (xe == EXP_ONES);
  assign y_spec = y_zero || (ye == EXP_ONES);
  assign sgn    = xs ^ ys;

  assign z_qnan = {1'b0, EXP_ONES, {1'b1, {(MAN_W-1){1'b0}}}};
  assign z_inf  = {sgn, EXP_ONES, {MAN_W{1'b0}}};
  assign z_zero = {sgn, {(W-1){1'b0}}};

  // Restoring divide step: subtract when the partial remainder covers the
  // divisor, then shift the remainder for the next quotient bit.
  logic             div_ge;
  logic [MAN_W+1:0] rem_sub;

  assign div_ge  = (rem_q >= {1'b0, dvs_q});
  assign rem_sub = div_ge ? (rem_q - {1'b0, dvs_q}) : rem_q;

  // Rounding increment. quo_q is normalised by the time PACK uses it:
  // quo_q[QW-1] hidden, quo_q[QW-2:2] mantissa, quo_q[1] guard, quo_q[0]
  // plus any leftover remainder form the sticky bit.
  logic round_up;
`ifdef FP_DIV_ROUND_EN
  assign round_up = quo_q[1] & (quo_q[2] | quo_q[0] | (|rem_q));
`else
  assign round_up = 1'b0;
`endif

  logic [MAN_W+1:0]      man_rnd;
  logic                  rnd_carry;
  logic [MAN_W-1:0]      man_fin;
  logic signed [EW-1:0]  exp_rnd;

  // Rounded significand and exponent feeding the PACK range check.
  always_comb begin
    man_rnd   = {1'b0, quo_q[QW-1:2]} + (MAN_W+2)'(round_up);
    rnd_carry = man_rnd[MAN_W+1];
    man_fin   = rnd_carry ? man_rnd[MAN_W:1] : man_rnd[MAN_W-1:0];
    exp_rnd   = exp_q + EW'(rnd_carry);
  end

  // Next-state and datapath updates for the sequencing FSM.
  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    spz_d   = spz_q;
    spf_d   = spf_q;
    z_d     = z_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (div_if.enable) begin
          sign_d = sgn;
          exp_d  = EW'(xe) - EW'(ye) + EW'(BIAS);
          rem_d  = {1'b0, 1'b1, xm};
          dvs_d  = {1'b1, ym};
          quo_d  = '0;
          cnt_d  = CNT_LOAD;
          if (x_nan || y_nan || (x_zero && y_zero) || (x_inf && y_inf)) begin
            spz_d = z_qnan;
            spf_d = 2'b11;
          end else if (y_zero) begin
            spz_d = z_inf;
            spf_d = 2'b11;
          end else if (x_inf) begin
            spz_d = z_inf;
            spf_d = 2'b00;
          end else begin
            spz_d = z_zero;
            spf_d = 2'b00;
          end
          state_d = (x_spec || y_spec) ? S_SPEC : S_DIV;
        end
      end

      S_DIV: begin
        quo_d = {quo_q[QW-2:0], div_ge};
        rem_d = rem_sub << 1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = S_NORM;
        end
      end

      S_NORM: begin
        if (!quo_q[QW-1]) begin
          quo_d = quo_q << 1;
          exp_d = exp_q - EW'(1);
        end
        state_d = S_PACK;
      end

      S_PACK: begin
        if (exp_rnd >= EXP_TOP) begin
          z_d   = {sign_q, EXP_ONES, {MAN_W{1'b0}}};
          ovf_d = 2'b01;
        end else if (exp_rnd <= EXP_ZERO) begin
          z_d   = {sign_q, {(W-1){1'b0}}};
          ovf_d = 2'b10;
        end else begin
          z_d   = {sign_q, exp_rnd[EXP_W-1:0], man_fin};
          ovf_d = 2'b00;
        end
        valid_d = 1'b1;
        state_d = S_IDLE;
      end

      S_SPEC: begin
        z_d     = spz_q;
        ovf_d   = spf_q;
        valid_d = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      spz_q   <= '0;
      spf_q   <= 2'b00;
      z_q     <= '0;
      ovf_q   <= 2'b00;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      spz_q   <= spz_d;
      spf_q   <= spf_d;
      z_q     <= z_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign div_if.busy     = (state_q != S_IDLE);
  assign div_if.valid    = valid_q;
  assign div_if.z        = z_q;
  assign div_if.overflow = ovf_q;

endmodule

// File: doc/fp_div_iter.md
# fp_div_iter

Parametrised, multi-cycle IEEE-754-style floating-point divider computing z = x / y with a start/valid handshake, a busy indication and a 2-bit exception flag. It is the generalised successor of the single-precision divider in the floating-point unit. Exponent and mantissa widths are configurable. The mantissa quotient is produced by a one-bit-per-cycle restoring divider, so one divider instance serves single, half or custom formats in the arithmetic datapath.

## Interface
- EXP_W, 8, exponent field width (bias = 2^(EXP_W-1)-1)
- MAN_W, 23, stored mantissa width (hidden bit implicit)
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- enable  in  1  start request, sampled only in IDLE
- x  in  1+EXP_W+MAN_W  dividend {sign, exp, man}
- y  in  1+EXP_W+MAN_W  divisor
- busy  out  1  high while an operation is in flight
- valid  out  1  one-cycle pulse, z/overflow updated this cycle
- z  out  1+EXP_W+MAN_W  quotient, held until next result
- overflow  out  2  00 normal, 01 overflow, 10 underflow, 11 invalid/divide-by-zero

## Operation
- States: IDLE, DIV, NORM, PACK, SPEC.
- IDLE with enable=1: register the operands, sign = xs^ys, and exponent difference ex-ey+bias in a signed EXP_W+2-bit register. Load the mantissas with the hidden bit. Go to DIV, or to SPEC if a special case applies.
- Denormal inputs (exp=0) are treated as signed zero. Denormal results are flushed to zero.
- DIV: restoring division, one quotient bit per cycle, MAN_W+3 cycles; counter counts down to 0. The remainder OR-reduces into a sticky bit.
- NORM: if the quotient MSB is 0 (quotient < 1), shift left 1 and decrement the exponent.
- PACK: round, then apply the range check and register z, overflow and valid.
  - If rounding carries out of the mantissa, increment the exponent.
  - If exp ≥ 2^EXP_W-1: z = signed infinity, flag 01.
  - If exp ≤ 0: z = signed zero, flag 10.
  - Otherwise pack the result, flag 00.
  - Then return to IDLE.
- SPEC results, in priority order:
  - NaN input, 0/0, or inf/inf: z = {0, all-ones exp, MSB-only mantissa} (quiet NaN), flag 11.
  - Finite nonzero / 0: signed infinity, flag 11.
  - inf / finite: signed infinity, flag 00.
  - 0 / nonzero, or finite / inf: signed zero, flag 00.
- enable while busy=1 is ignored. No queuing.

## Timing
- Reset values: busy=0, valid=0, z=0, overflow=2'b00, state IDLE, internal registers cleared.
- Accept edge = first rising edge with state IDLE and enable=1. busy rises on that edge.
- Normal path latency: valid=1 in the cycle following the MAN_W+5th edge after accept, i.e. MAN_W+5 cycles (28 for default parameters). busy falls on the same edge that raises valid.
- Special path latency: 2 cycles (accept edge → SPEC, next edge → valid).
- enable=1 during the valid cycle is accepted, allowing back-to-back operations with no bubble beyond the IDLE cycle.
- rst mid-operation aborts the operation on that edge. No valid is issued, and z is cleared to 0.
- x and y may change after the accept edge. Only registered copies are used.

## Configuration
- FP_DIV_ROUND_EN defined: round-to-nearest-even using the guard bit plus sticky (remainder ≠ 0 or lower quotient bits).
- Not defined: truncate (round toward zero). The guard and sticky logic is removed, and the carry-out exponent increment is never taken. Latency is unchanged.

## Test plan
- 12/6: x=0x41400000, y=0x40C00000, enable one cycle → z=0x40000000, overflow=00, valid exactly 28 cycles after accept, busy high throughout.
- 1/3: x=0x3F800000, y=0x40400000 → z=0x3EAAAAAB with FP_DIV_ROUND_EN, 0x3EAAAAAA without.
- -7.5/2.5: 0xC0F00000 / 0x40200000 → 0xC0400000, then back-to-back enable in the valid cycle with 0x7F000000/0x3E800000 → 0x7F800000, flag 01.
- Specials:
  - 0x3F800000/0x00000000 → 0x7F800000, flag 11, latency 2.
  - 0/0 → 0x7FC00000, flag 11.
  - 0x00800000/0x40000000 → 0x00000000, flag 10.
- Protocol: second enable pulse with different operands while busy → ignored, first result unchanged. Assert rst at cycle 10 of an operation → no valid, all outputs 0, next accept after reset completes normally.
- Parameter sweep: EXP_W=5, MAN_W=10 (half precision): 0x4A00/0x4600 (12/6) → 0x4000 after 15 cycles.
